// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C engine among four requesters.
// Watches engine start and completion, and aborts the engine on error or timeout.
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned START_WAIT     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [27:0] req_slave_addr,
  input  logic [63:0] req_reg_addr,
  input  logic [3:0]  req_is_read,
  input  logic [39:0] req_nb_bytes,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic        eng_start,
  output logic [6:0]  eng_slave_addr,
  output logic [15:0] eng_reg_addr,
  output logic        eng_is_read,
  output logic [9:0]  eng_nb_bytes,
  output logic [7:0]  eng_data_in,
  output logic        eng_reset,
  input  logic        eng_ready,
  input  logic        eng_error
);

  localparam int unsigned MaxWait  = (TIMEOUT_CYCLES > START_WAIT) ? TIMEOUT_CYCLES : START_WAIT;
  localparam int unsigned CntWidth = ($clog2(MaxWait + 1) > 17) ? $clog2(MaxWait + 1) : 17;

  // Abort fires on the last allowed cycle, so compare against limit - 1.
  localparam logic [CntWidth-1:0] StartLast =
      CntWidth'((START_WAIT == 0) ? 0 : START_WAIT - 1);
  localparam logic [CntWidth-1:0] TimeoutLast =
      CntWidth'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StIssue     = 3'd1;
  localparam logic [2:0] StWaitBusy  = 3'd2;
  localparam logic [2:0] StWaitDone  = 3'd3;
  localparam logic [2:0] StRelease   = 3'd4;
  localparam logic [2:0] StAbort     = 3'd5;
  localparam logic [2:0] StAbortHold = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          done_q, done_d;
  logic [3:0]          err_q, err_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                eng_reset_q, eng_reset_d;
  logic                latch_en;

  logic [6:0]          slave_addr_q;
  logic [15:0]         reg_addr_q;
  logic                is_read_q;
  logic [9:0]          nb_bytes_q;

  logic [1:0]          winner;
  logic                found;
  logic [1:0]          idx;
  logic [6:0]          sel_slave_addr;
  logic [15:0]         sel_reg_addr;
  logic                sel_is_read;
  logic [9:0]          sel_nb_bytes;
  logic [7:0]          data_mux;

  // Round-robin search starting at ptr_q, wrapping modulo 4.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_slave_addr = '0;
    sel_reg_addr   = '0;
    sel_is_read    = 1'b0;
    sel_nb_bytes   = '0;
    data_mux       = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) begin
        sel_slave_addr = req_slave_addr[7*i +: 7];
        sel_reg_addr   = req_reg_addr[16*i +: 16];
        sel_is_read    = req_is_read[i];
        sel_nb_bytes   = req_nb_bytes[10*i +: 10];
      end
      if (grant_q[i]) begin
        data_mux = req_data[8*i +: 8];
      end
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    done_d      = '0;
    err_d       = '0;
    eng_reset_d = 1'b0;
    latch_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d  = 4'b0001 << winner;
          owner_d  = winner;
          latch_en = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!eng_ready) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q >= StartLast) begin
          err_d       = grant_q;
          eng_reset_d = 1'b1;
          state_d     = StAbort;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitDone: begin
        // Error outranks a simultaneous ready.
        if (eng_error) begin
          err_d       = grant_q;
          eng_reset_d = 1'b1;
          state_d     = StAbort;
        end else if (eng_ready) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = StRelease;
        end else if (cnt_q >= TimeoutLast) begin
          err_d       = grant_q;
          eng_reset_d = 1'b1;
          state_d     = StAbort;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease: begin
        ptr_d   = owner_q + 2'd1;
        state_d = StIdle;
      end
      StAbort: begin
        eng_reset_d = 1'b1;
        state_d     = StAbortHold;
      end
      StAbortHold: begin
        grant_d = '0;
        ptr_d   = owner_q + 2'd1;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      eng_reset_q  <= 1'b0;
      slave_addr_q <= '0;
      reg_addr_q   <= '0;
      is_read_q    <= 1'b0;
      nb_bytes_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      eng_reset_q <= eng_reset_d;
      if (latch_en) begin
        slave_addr_q <= sel_slave_addr;
        reg_addr_q   <= sel_reg_addr;
        is_read_q    <= sel_is_read;
        nb_bytes_q   <= sel_nb_bytes;
      end
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign err            = err_q;
  assign eng_start      = (state_q == StIssue);
  // Engine is held in reset while the arbiter itself is in reset.
  assign eng_reset      = eng_reset_q | reset;
  assign eng_slave_addr = slave_addr_q;
  assign eng_reg_addr   = reg_addr_q;
  assign eng_is_read    = is_read_q;
  assign eng_nb_bytes   = nb_bytes_q;
  assign eng_data_in    = data_mux;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios then randomized traffic, checked against
// a transaction-level round-robin and timeline model.
module tb_i2c_bus_arbiter;

  localparam int unsigned TimeoutCycles = 100;
  localparam int unsigned StartWait     = 16;
  localparam int ModeOk      = 0;
  localparam int ModeErr     = 1;
  localparam int ModeStartTo = 2;
  localparam int ModeDoneTo  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] req_slave_addr = '0;
  logic [63:0] req_reg_addr = '0;
  logic [3:0]  req_is_read = '0;
  logic [39:0] req_nb_bytes = '0;
  logic [31:0] req_data = '0;
  logic        eng_ready = 1'b1;
  logic        eng_error = 1'b0;
  logic [3:0]  grant, done, err;
  logic        eng_start, eng_is_read, eng_reset;
  logic [6:0]  eng_slave_addr;
  logic [15:0] eng_reg_addr;
  logic [9:0]  eng_nb_bytes;
  logic [7:0]  eng_data_in;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  logic [6:0]  exp_sa = '0;
  logic [15:0] exp_ra = '0;
  logic        exp_rd = 1'b0;
  logic [9:0]  exp_nb = '0;

  always #5 clock = ~clock;

  i2c_bus_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .START_WAIT    (StartWait)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_slave_addr(req_slave_addr),
    .req_reg_addr  (req_reg_addr),
    .req_is_read   (req_is_read),
    .req_nb_bytes  (req_nb_bytes),
    .req_data      (req_data),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .eng_start     (eng_start),
    .eng_slave_addr(eng_slave_addr),
    .eng_reg_addr  (eng_reg_addr),
    .eng_is_read   (eng_is_read),
    .eng_nb_bytes  (eng_nb_bytes),
    .eng_data_in   (eng_data_in),
    .eng_reset     (eng_reset),
    .eng_ready     (eng_ready),
    .eng_error     (eng_error)
  );

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s t=%0t got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic [3:0] e, input logic s, input logic r);
    n_tests++;
    assert ({grant, done, err, eng_start, eng_reset} === {g, d, e, s, r}) else begin
      n_fail++;
      $error("FAIL %s t=%0t got grant=%b done=%b err=%b start=%b ereset=%b expected %b %b %b %b %b",
             tag, $time, grant, done, err, eng_start, eng_reset, g, d, e, s, r);
    end
  endtask

  task automatic check_fields(input string tag);
    check_val(tag, {30'd0, eng_slave_addr, eng_reg_addr, eng_is_read, eng_nb_bytes},
              {30'd0, exp_sa, exp_ra, exp_rd, exp_nb});
  endtask

  task automatic rand_fields(input int i);
    req_slave_addr[7*i +: 7] = 7'($urandom);
    req_reg_addr[16*i +: 16] = 16'($urandom);
    req_is_read[i]           = 1'($urandom);
    req_nb_bytes[10*i +: 10] = 10'($urandom);
    req_data[8*i +: 8]       = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1 check_val("eng_reset_during_reset", 64'(eng_reset), 64'd1);
    @(negedge clock);
    check_outs("reset_outputs", 4'b0, 4'b0, 4'b0, 1'b0, 1'b1);
    exp_sa = '0; exp_ra = '0; exp_rd = 1'b0; exp_nb = '0;
    check_fields("reset_fields");
    reset     = 1'b0;
    eng_ready = 1'b1;
    eng_error = 1'b0;
    ptr_m     = 0;
    @(negedge clock);
    check_outs("post_reset", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  // Idle cycles until some request is pending; returns the model's round-robin winner.
  task automatic idle_phase(input logic [3:0] add_req, input bit rnd, output int w);
    int cyc;
    cyc = 0;
    w   = -1;
    while (w < 0) begin
      @(negedge clock);
      check_outs("idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
      if (cyc == 0) begin
        for (int i = 0; i < 4; i++) begin
          if (add_req[i] && !req[i]) begin rand_fields(i); req[i] = 1'b1; end
        end
      end
      if (rnd) begin
        for (int i = 0; i < 4; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin rand_fields(i); req[i] = 1'b1; end
        end
      end
      if (cyc >= 3 && req == 4'b0) begin
        int i;
        i = $urandom_range(0, 3);
        rand_fields(i);
        req[i] = 1'b1;
      end
      #1 check_val("idle_data", 64'(eng_data_in), 64'd0);
      if (req != 4'b0) begin
        w      = rr_pick(req, ptr_m);
        exp_sa = req_slave_addr[7*w +: 7];
        exp_ra = req_reg_addr[16*w +: 16];
        exp_rd = req_is_read[w];
        exp_nb = req_nb_bytes[10*w +: 10];
      end
      cyc++;
    end
  endtask

  // One granted transaction, cycle by cycle from the eng_start cycle (t = 0).
  task automatic run_txn(input int w, input int mode, input int a, input int b, input int e,
                         input bit err_ready, input int kill_at, input bit rnd);
    logic [3:0] oh;
    int t_end, last, mid;
    bit ok, dropped;
    oh      = 4'b0001 << w;
    ok      = (mode == ModeOk);
    dropped = 1'b0;
    if (mode == ModeOk)           t_end = a + b + 1;
    else if (mode == ModeErr)     t_end = a + e + 1;
    else if (mode == ModeStartTo) t_end = int'(StartWait) + 1;
    else                          t_end = a + int'(TimeoutCycles) + 1;
    last = ok ? t_end : t_end + 1;
    mid  = $urandom_range(1, t_end - 1);
    for (int t = 0; t <= last; t++) begin
      @(negedge clock);
      if (t < t_end)     check_outs("busy", oh, 4'b0, 4'b0, t == 0, 1'b0);
      else if (t == t_end && ok) check_outs("release", 4'b0, oh, 4'b0, 1'b0, 1'b0);
      else if (t == t_end) check_outs("abort_first", oh, 4'b0, oh, 1'b0, 1'b1);
      else               check_outs("abort_second", oh, 4'b0, 4'b0, 1'b0, 1'b1);
      if (t == 0 || t == last) check_fields("latched_fields");
      if (t == kill_at) return;
      if (mode == ModeOk) begin
        eng_ready = !(t >= a && t < a + b);
      end else if (mode == ModeErr) begin
        eng_ready = !(t >= a);
        eng_error = (t >= a + e);
        if (err_ready && t >= a + e) eng_ready = 1'b1;
      end else if (mode == ModeStartTo) begin
        eng_ready = 1'b1;
      end else begin
        eng_ready = !(t >= a);
      end
      if (t >= t_end) begin eng_ready = 1'b1; eng_error = 1'b0; end
      if (rnd) begin
        if (t == mid) begin
          rand_fields(w);
          if ($urandom_range(0, 3) == 0) begin req[w] = 1'b0; dropped = 1'b1; end
        end
        for (int i = 0; i < 4; i++) begin
          if (i != w && !req[i] && $urandom_range(0, 15) == 0) begin
            rand_fields(i);
            req[i] = 1'b1;
          end
        end
        if (t == t_end && !dropped && $urandom_range(0, 1) == 0) req[w] = 1'b0;
      end
      #1 check_val("data_mux", 64'(eng_data_in),
                   (t < t_end || !ok) ? 64'(req_data[8*w +: 8]) : 64'd0);
    end
    ptr_m = (w + 1) % 4;
  endtask

  initial begin
    int w, mode;
    @(negedge clock);
    apply_reset();

    // All four requesting and holding: rotation 0,1,2,3,0.
    idle_phase(4'b1111, 1'b0, w);
    for (int k = 0; k < 5; k++) begin
      run_txn(w, ModeOk, $urandom_range(1, 5), $urandom_range(1, 10), 0, 1'b0, -1, 1'b0);
      if (k < 4) idle_phase(4'b0000, 1'b0, w);
    end
    req = '0;

    idle_phase(4'b0100, 1'b0, w);
    run_txn(w, ModeOk, 2, 50, 0, 1'b0, -1, 1'b0);
    req = '0;
    idle_phase(4'b0001, 1'b0, w);
    run_txn(w, ModeErr, 3, 0, 5, 1'b0, -1, 1'b0);
    req = '0;
    idle_phase(4'b0010, 1'b0, w);
    run_txn(w, ModeStartTo, 0, 0, 0, 1'b0, -1, 1'b0);
    req = '0;
    idle_phase(4'b1000, 1'b0, w);
    run_txn(w, ModeDoneTo, 3, 0, 0, 1'b0, -1, 1'b0);
    req = '0;
    // Error and ready together: error must win.
    idle_phase(4'b0100, 1'b0, w);
    run_txn(w, ModeErr, 4, 0, 1, 1'b1, -1, 1'b0);
    req = '0;

    // Reset while waiting on the engine; pointer must restart at 0.
    idle_phase(4'b0100, 1'b0, w);
    run_txn(w, ModeOk, 2, 50, 0, 1'b0, 10, 1'b0);
    req = '0;
    apply_reset();
    repeat (4) begin
      @(negedge clock);
      check_outs("after_kill", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    end
    idle_phase(4'b1010, 1'b0, w);
    run_txn(w, ModeOk, 1, 3, 0, 1'b0, -1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      idle_phase(4'b0000, 1'b1, w);
      mode = $urandom_range(0, 9);
      if (mode <= 5)      mode = ModeOk;
      else if (mode <= 7) mode = ModeErr;
      else if (mode == 8) mode = ModeStartTo;
      else                mode = ModeDoneTo;
      run_txn(w, mode, $urandom_range(1, 16), $urandom_range(1, 40), $urandom_range(1, 30),
              1'($urandom_range(0, 1)), -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 100000, max cycles in WAIT_DONE before abort.
REQ-002 Parameter: START_WAIT, 16, max cycles for engine to drop eng_ready after eng_start.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester transaction request, level, held until done/err.
REQ-006 req_slave_addr  input  28  4x7-bit slave address, requester i at [7i+6:7i].
REQ-007 req_reg_addr  input  64  4x16-bit register address, requester i at [16i+15:16i].
REQ-008 req_is_read  input  4  per-requester read (1) / write (0).
REQ-009 req_nb_bytes  input  40  4x10-bit byte count, requester i at [10i+9:10i].
REQ-010 req_data  input  32  4x8-bit write byte, requester i at [8i+7:8i].
REQ-011 grant  output  4  one-hot owner of engine, 0 when idle.
REQ-012 done  output  4  one-cycle pulse, transaction completed OK.
REQ-013 err  output  4  one-cycle pulse, transaction failed (engine error, start timeout, done timeout).
REQ-014 eng_start  output  1  one-cycle start strobe to I2C engine.
REQ-015 eng_slave_addr / eng_reg_addr / eng_is_read / eng_nb_bytes  output  7/16/1/10  latched fields of granted requester.
REQ-016 eng_data_in  output  8  combinational mux of req_data of granted requester; 0 when no grant.
REQ-017 eng_reset  output  1  engine abort/reset, active-high.
REQ-018 eng_ready  input  1  engine idle/complete; low while busy.
REQ-019 eng_error  input  1  engine error flag, level.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE, ABORT.
REQ-021 IDLE: if any req bit set, select winner round-robin starting at pointer ptr (search ptr, ptr+1, ... mod 4); next cycle grant=onehot(winner), eng_* fields latched from winner, state ISSUE.
REQ-022 Fields latched once at grant; later requester field changes ignored until next grant.
REQ-023 ISSUE: eng_start=1 for exactly this one cycle; -> WAIT_BUSY; counter cleared.
REQ-024 WAIT_BUSY: eng_ready=0 -> WAIT_DONE, counter cleared; counter reaching START_WAIT with eng_ready still 1 -> ABORT.
REQ-025 WAIT_DONE: eng_error=1 -> ABORT (error priority over eng_ready); else eng_ready=1 -> RELEASE with success; else counter reaching TIMEOUT_CYCLES -> ABORT.
REQ-026 RELEASE: done[owner] pulsed one cycle, grant cleared same cycle, ptr=(owner+1) mod 4, -> IDLE.
REQ-027 ABORT: eng_reset=1 for 2 cycles, err[owner] pulsed on first ABORT cycle, grant cleared after the 2nd cycle, ptr=(owner+1) mod 4, -> IDLE.
REQ-028 Requester dropping req mid-transaction: transaction continues; done/err still pulsed to that requester.
REQ-029 Requester holding req after done: eligible again only after other pending requesters per round-robin.
REQ-030 Earliest re-grant: IDLE cycle following RELEASE/ABORT; minimum 1 idle cycle between transactions.
REQ-031 Counter 17 bits min, saturates; never wraps.
REQ-032 done and err never both asserted; at most one bit of grant/done/err set.

Reset
REQ-033 Reset (any state, incl. mid-transaction): state IDLE, grant=0, done=0, err=0, eng_start=0, eng_reset=1 during reset and 0 the cycle after, latched fields=0, ptr=0, counter=0.
REQ-034 No done/err pulse is emitted for a transaction killed by reset.

Verification
REQ-035 req=4'b0100, eng_ready drops 2 cycles after start, rises 50 cycles later -> grant=4'b0100, one eng_start pulse, done=4'b0100 pulse, grant=0 next.
REQ-036 req=4'b1111 held, engine completes each -> grant order 0001,0010,0100,1000,0001.
REQ-037 Granted req 0, eng_error=1 during WAIT_DONE -> eng_reset high 2 cycles, err=4'b0001, no done.
REQ-038 eng_ready stays 1 after eng_start for 16 cycles -> ABORT, err pulsed; TIMEOUT_CYCLES=100 with engine stuck busy -> err after 100 cycles.
REQ-039 reset asserted in WAIT_DONE -> all outputs to reset values, no done/err, next req granted from ptr=0.
